// File: rtl/tdm_demux_pkg.sv
// Shared types and constants for the TDM demultiplexer.
// Lock states, default sizing and a slot-width helper.
package tdm_demux_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int DEF_NUM_CH = 8;
  localparam int DEF_CH_W   = 1;

  function automatic int sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Modulo-NUM_CH slot counter: clr > load-to-1 > increment.
// Ports: en, load1, clr in; slot index and last-slot flag (wrap) out.
module tdm_slot_ctr
  import tdm_demux_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int SEL_W  = sel_w(NUM_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load1,
  input  logic             clr,
  output logic [SEL_W-1:0] slot,
  output logic             wrap
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_CH - 1);
  localparam logic [SEL_W-1:0] ONE  = SEL_W'(1);

  logic [SEL_W-1:0] slot_d;
  logic [SEL_W-1:0] slot_q;

  always_comb begin
    slot_d = slot_q;
    if (clr) begin
      slot_d = '0;
    end else if (load1) begin
      slot_d = ONE;
    end else if (en) begin
      slot_d = (slot_q == LAST) ? '0 : slot_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot = slot_q;
  assign wrap = (slot_q == LAST);

endmodule

// File: rtl/tdm_demux.sv
// Slot-serial to parallel TDM demultiplexer with a HUNT/LOCKED FSM.
// Ports: din/din_valid/fsync in; dout, dout_valid, slot, locked, sync_err out.
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CH_W   = DEF_CH_W,
  parameter int SEL_W  = sel_w(NUM_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CH_W-1:0]        din,
  input  logic                   din_valid,
  input  logic                   fsync,
  output logic [NUM_CH*CH_W-1:0] dout,
  output logic                   dout_valid,
  output logic [SEL_W-1:0]       slot,
  output logic                   locked,
  output logic                   sync_err
);

  localparam int LO_W = (NUM_CH - 1) * CH_W;

  state_e                   state_d, state_q;
  logic [NUM_CH*CH_W-1:0]   shadow_d, shadow_q;
  logic [NUM_CH*CH_W-1:0]   dout_d, dout_q;
  logic                     dv_d, dv_q;
  logic                     err_d, err_q;
  logic                     ctr_en;
  logic                     ctr_load1;
  logic                     ctr_clr;
  logic                     wrap;
  logic                     slot0;

  tdm_slot_ctr #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ctr_en),
    .load1 (ctr_load1),
    .clr   (ctr_clr),
    .slot  (slot),
    .wrap  (wrap)
  );

  assign slot0 = (slot == '0);

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    dout_d    = dout_q;
    dv_d      = 1'b0;
    err_d     = 1'b0;
    ctr_en    = 1'b0;
    ctr_load1 = 1'b0;
    ctr_clr   = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (fsync) begin
            shadow_d[CH_W-1:0] = din;
            ctr_load1          = 1'b1;
            state_d            = LOCKED;
          end
        end
        LOCKED: begin
          unique case (1'b1)
            fsync: begin
              // early sync drops the partial frame and restarts
              shadow_d[CH_W-1:0] = din;
              ctr_load1          = 1'b1;
              err_d              = !slot0;
            end
            (!fsync && slot0): begin
              err_d   = 1'b1;
              ctr_clr = 1'b1;
              state_d = HUNT;
            end
            default: begin
              shadow_d[int'(slot)*CH_W +: CH_W] = din;
              ctr_en = 1'b1;
              if (wrap) begin
                dout_d = {din, shadow_q[LO_W-1:0]};
                dv_d   = 1'b1;
              end
            end
          endcase
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      shadow_q <= '0;
      dout_q   <= '0;
      dv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      dv_q     <= dv_d;
      err_q    <= err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign locked     = (state_q == LOCKED);
  assign sync_err   = err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux (NUM_CH=8, CH_W=1).
// Vector table, directed corner sequences and a random run vs a queue model.
module tb_tdm_demux;

  localparam int NUM_CH = 8;
  localparam int CH_W   = 1;
  localparam int SEL_W  = 3;
  localparam int DW     = NUM_CH * CH_W;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [CH_W-1:0] din = '0;
  logic            din_valid = 1'b0;
  logic            fsync = 1'b0;
  logic [DW-1:0]   dout;
  logic            dout_valid;
  logic [SEL_W-1:0] slot;
  logic            locked;
  logic            sync_err;

  int checks = 0;
  int failures = 0;

  tdm_demux #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W),
    .SEL_W  (SEL_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .fsync      (fsync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .slot       (slot),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  // Reference model: a frame is a queue of samples collected since sync.
  bit              m_locked;
  logic [CH_W-1:0] m_q[$];
  logic [DW-1:0]   m_dout;
  bit              m_dv;
  bit              m_err;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp,
               $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_q.delete();
    m_dout = '0;
    m_dv = 0;
    m_err = 0;
  endtask

  task automatic model_step(input bit v, input bit f, input logic [CH_W-1:0] d);
    m_dv = 0;
    m_err = 0;
    if (!v) return;
    if (!m_locked) begin
      if (f) begin
        m_q = '{d};
        m_locked = 1;
      end
    end else if (f) begin
      m_err = (m_q.size() != 0);
      m_q = '{d};
    end else if (m_q.size() == 0) begin
      m_err = 1;
      m_locked = 0;
    end else begin
      m_q.push_back(d);
      if (m_q.size() == NUM_CH) begin
        for (int i = 0; i < NUM_CH; i++) m_dout[i*CH_W +: CH_W] = m_q[i];
        m_dv = 1;
        m_q.delete();
      end
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".dout"}, dout, m_dout);
    chk({tag, ".dv"}, dout_valid, m_dv);
    chk({tag, ".slot"}, slot, m_locked ? m_q.size() : 0);
    chk({tag, ".locked"}, locked, m_locked);
    chk({tag, ".err"}, sync_err, m_err);
    chk({tag, ".excl"}, dout_valid & sync_err, 0);
  endtask

  task automatic step(input string tag, input bit v, input bit f,
                      input logic [CH_W-1:0] d);
    din_valid = v;
    fsync = f;
    din = d;
    @(posedge clk);
    #1;
    model_step(v, f, d);
    chk_model(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    model_reset();
    chk({tag, ".dout"}, dout, 0);
    chk({tag, ".dv"}, dout_valid, 0);
    chk({tag, ".slot"}, slot, 0);
    chk({tag, ".locked"}, locked, 0);
    chk({tag, ".err"}, sync_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic frame(input string tag, input logic [DW-1:0] bits);
    for (int i = 0; i < NUM_CH; i++) step(tag, 1, i == 0, bits[i]);
  endtask

  typedef struct {
    bit         v;
    bit         f;
    logic       d;
    logic [7:0] dout;
    bit         dv;
    bit         lk;
    bit         err;
    logic [2:0] slot;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [7:0] smp;
    int dv_cnt;
    smp = 8'h4D;
    for (int i = 0; i < 3; i++) tbl[i] = '{0, 1, 1, 8'h00, 0, 0, 0, 3'd0};
    for (int i = 0; i < 8; i++)
      tbl[3+i] = '{1, i == 0, smp[i], (i == 7) ? 8'h4D : 8'h00,
                   i == 7, 1, 0, 3'((i + 1) % 8)};
    tbl[11] = '{0, 0, 0, 8'h4D, 0, 1, 0, 3'd0};

    model_reset();
    #1;
    do_reset("rst");

    // idle, then lock and capture 0x4D
    for (int i = 0; i < 12; i++) begin
      step("tbl", tbl[i].v, tbl[i].f, tbl[i].d);
      chk("tbl.dout", dout, tbl[i].dout);
      chk("tbl.dv", dout_valid, tbl[i].dv);
      chk("tbl.lk", locked, tbl[i].lk);
      chk("tbl.err", sync_err, tbl[i].err);
      chk("tbl.slot", slot, tbl[i].slot);
    end

    // gapped frame with fsync inside the gap
    dv_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step("gap", 1, i == 0, smp[i]);
      dv_cnt += dout_valid;
    end
    for (int i = 0; i < 3; i++) begin
      step("gap.idle", 0, 1, 1);
      chk("gap.slot_hold", slot, 4);
      dv_cnt += dout_valid;
    end
    for (int i = 4; i < 8; i++) begin
      step("gap", 1, 0, smp[i]);
      dv_cnt += dout_valid;
    end
    chk("gap.dv_last", dout_valid, 1);
    chk("gap.dout", dout, 8'h4D);
    chk("gap.dv_count", dv_cnt, 1);

    // early sync after 5 samples
    for (int i = 0; i < 5; i++) step("early", 1, i == 0, 1);
    step("early.sync", 1, 1, 1);
    chk("early.err", sync_err, 1);
    chk("early.slot", slot, 1);
    for (int i = 0; i < 7; i++) begin
      step("early.fill", 1, 0, 0);
      if (i < 6) chk("early.hold", dout, 8'h4D);
    end
    chk("early.dout", dout, 8'h01);
    chk("early.dv", dout_valid, 1);

    // missing sync, then relock
    frame("miss.f", 8'hA5);
    chk("miss.dout1", dout, 8'hA5);
    step("miss", 1, 0, 1);
    chk("miss.err", sync_err, 1);
    chk("miss.lk", locked, 0);
    frame("miss.relock", 8'h3C);
    chk("miss.dout2", dout, 8'h3C);
    chk("miss.dv", dout_valid, 1);

    // reset mid-frame
    for (int i = 0; i < 5; i++) step("mrst", 1, i == 0, 1);
    do_reset("mrst.rst");
    for (int i = 0; i < 3; i++) step("mrst.hunt", 1, 0, 1);
    chk("mrst.lk", locked, 0);
    frame("mrst.f", 8'h96);
    chk("mrst.dout", dout, 8'h96);
    chk("mrst.dv", dout_valid, 1);

    // full-rate back-to-back frames
    dv_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      frame("b2b", 8'($urandom));
      dv_cnt += dout_valid;
    end
    chk("b2b.count", dv_cnt, 4);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      bit v, f;
      if ($urandom_range(0, 599) == 0) begin
        do_reset("rnd.rst");
      end else begin
        v = ($urandom_range(0, 3) != 0);
        if (m_locked && m_q.size() != 0) f = ($urandom_range(0, 39) == 0);
        else f = ($urandom_range(0, 9) != 0);
        step("rnd", v, f, CH_W'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
